mask_region_stats: RTL and testbench

- Stream sink at the far end of the binary skin-mask video pipeline. Consumes the filtered one-bit mask with its de/hsync/vsync timing.
- Per frame it accumulates:
  - mask pixel count
  - bounding box
  - coordinate sums
- At each frame boundary it snapshots these values and computes the integer centroid with a sequential divider.
- It presents one registered result set per frame to the tracking/overlay logic.

---
 rtl/mask_region_stats.sv | 228 ++++++++++++++++++++++
 tb/tb_mask_region_stats.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_region_stats.sv
// mask_region_stats: per-frame statistics of a one-bit mask stream.
// Accumulates pixel count, bounding box and coordinate sums while video is
// active. At every vsync rising edge it snapshots them and runs a restoring
// divider twice (x, then y) to produce the integer centroid. The result is
// published as one registered set with a single-cycle out_valid pulse.
//
// Handshake: there is no backpressure. out_valid is a one-enabled-cycle
// pulse; the out_* registers change only in that cycle and hold otherwise.
// overrun pulses when a frame boundary arrives while a previous frame is
// still being divided; that newer frame's result is dropped.
module mask_region_stats #(
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int CNT_W = 20,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mask,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  output logic             out_valid,
  output logic             out_found,
  output logic [CNT_W-1:0] out_count,
  output logic [X_W-1:0]   out_x_min,
  output logic [X_W-1:0]   out_x_max,
  output logic [Y_W-1:0]   out_y_min,
  output logic [Y_W-1:0]   out_y_max,
  output logic [X_W-1:0]   out_cx,
  output logic [Y_W-1:0]   out_cy,
  output logic             overrun
);

  localparam int IT_W = $clog2(SUM_W);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  // FSM state; kept as a named signal so checkers can bind to it
  state_t state;

  // Edge detectors and coordinates
  logic           prev_de;
  logic           prev_vs;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  // Running accumulators for the current frame
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic [X_W-1:0]   x_min;
  logic [X_W-1:0]   x_max;
  logic [Y_W-1:0]   y_min;
  logic [Y_W-1:0]   y_max;

  // Frame snapshot taken at the boundary
  logic [CNT_W-1:0] snap_count;
  logic [SUM_W-1:0] snap_sum_y;
  logic [X_W-1:0]   snap_x_min;
  logic [X_W-1:0]   snap_x_max;
  logic [Y_W-1:0]   snap_y_min;
  logic [Y_W-1:0]   snap_y_max;

  // Divider datapath: dvd shifts the dividend out and the quotient in
  logic [SUM_W-1:0] dvd;
  logic [SUM_W-1:0] rem;
  logic [IT_W-1:0]  iter;
  logic [X_W-1:0]   quo_x;

  logic             boundary;
  logic             de_fall;
  logic             hit;
  logic [SUM_W:0]   divisor_ext;
  logic [SUM_W:0]   trial;
  logic [SUM_W:0]   diff;
  logic             q_bit;
  logic [SUM_W-1:0] dvd_next;
  logic             unused_ok;

  assign boundary  = in_vsync & ~prev_vs;
  assign de_fall   = prev_de & ~in_de;
  assign hit       = in_de & mask;
  assign unused_ok = ^{in_hsync, diff[SUM_W]};

  // One restoring-division step; an empty frame divides by 1 so the
  // datapath stays well defined, and its quotient is discarded later
  always_comb begin
    divisor_ext = (snap_count == '0) ? (SUM_W+1)'(1) : (SUM_W+1)'(snap_count);
    trial       = {rem, dvd[SUM_W-1]};
    q_bit       = (trial >= divisor_ext);
    diff        = q_bit ? (trial - divisor_ext) : trial;
    dvd_next    = {dvd[SUM_W-2:0], q_bit};
  end

  // Coordinate tracking and per-frame accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_de <= 1'b0;
      prev_vs <= 1'b0;
      x       <= '0;
      y       <= '0;
      count   <= '0;
      sum_x   <= '0;
      sum_y   <= '0;
      x_min   <= '1;
      x_max   <= '0;
      y_min   <= '1;
      y_max   <= '0;
    end else if (ce) begin
      prev_de <= in_de;
      prev_vs <= in_vsync;
      x       <= in_de ? (x + X_W'(1)) : '0;
      if (boundary)     y <= '0;
      else if (de_fall) y <= y + Y_W'(1);
      if (boundary) begin
        count <= '0;
        sum_x <= '0;
        sum_y <= '0;
        x_min <= '1;
        x_max <= '0;
        y_min <= '1;
        y_max <= '0;
      end else if (hit) begin
        if (count != '1) count <= count + CNT_W'(1);
        sum_x <= sum_x + SUM_W'(x);
        sum_y <= sum_y + SUM_W'(y);
        if (x < x_min) x_min <= x;
        if (x > x_max) x_max <= x;
        if (y < y_min) y_min <= y;
        if (y > y_max) y_max <= y;
      end
    end
  end

  // Snapshot, centroid division and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap_count <= '0;
      snap_sum_y <= '0;
      snap_x_min <= '0;
      snap_x_max <= '0;
      snap_y_min <= '0;
      snap_y_max <= '0;
      dvd        <= '0;
      rem        <= '0;
      iter       <= '0;
      quo_x      <= '0;
      out_valid  <= 1'b0;
      out_found  <= 1'b0;
      out_count  <= '0;
      out_x_min  <= '0;
      out_x_max  <= '0;
      out_y_min  <= '0;
      out_y_max  <= '0;
      out_cx     <= '0;
      out_cy     <= '0;
      overrun    <= 1'b0;
    end else if (ce) begin
      out_valid <= 1'b0;
      overrun   <= boundary && (state != IDLE);
      case (state)
        IDLE: begin
          if (boundary) begin
            snap_count <= count;
            snap_sum_y <= sum_y;
            snap_x_min <= x_min;
            snap_x_max <= x_max;
            snap_y_min <= y_min;
            snap_y_max <= y_max;
            dvd        <= sum_x;
            rem        <= '0;
            iter       <= '0;
            state      <= DIV_X;
          end
        end
        DIV_X: begin
          iter <= iter + IT_W'(1);
          if (iter == IT_W'(SUM_W - 1)) begin
            quo_x <= dvd_next[X_W-1:0];
            dvd   <= snap_sum_y;
            rem   <= '0;
            iter  <= '0;
            state <= DIV_Y;
          end else begin
            dvd <= dvd_next;
            rem <= diff[SUM_W-1:0];
          end
        end
        DIV_Y: begin
          iter <= iter + IT_W'(1);
          dvd  <= dvd_next;
          rem  <= diff[SUM_W-1:0];
          if (iter == IT_W'(SUM_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          if (snap_count == '0) begin
            out_found <= 1'b0;
            out_count <= '0;
            out_x_min <= '0;
            out_x_max <= '0;
            out_y_min <= '0;
            out_y_max <= '0;
            out_cx    <= '0;
            out_cy    <= '0;
          end else begin
            out_found <= 1'b1;
            out_count <= snap_count;
            out_x_min <= snap_x_min;
            out_x_max <= snap_x_max;
            out_y_min <= snap_y_min;
            out_y_max <= snap_y_max;
            out_cx    <= quo_x;
            out_cy    <= dvd[Y_W-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_region_stats.sv
// tb_mask_region_stats: directed frames with hand-computed statistics.
module tb_mask_region_stats;

  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int CNT_W = 20;
  localparam int SUM_W = 32;
  localparam int LAT   = 66;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             mask;
  logic             in_de;
  logic             in_hsync;
  logic             in_vsync;
  logic             out_valid;
  logic             out_found;
  logic [CNT_W-1:0] out_count;
  logic [X_W-1:0]   out_x_min;
  logic [X_W-1:0]   out_x_max;
  logic [Y_W-1:0]   out_y_min;
  logic [Y_W-1:0]   out_y_max;
  logic [X_W-1:0]   out_cx;
  logic [Y_W-1:0]   out_cy;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  mask_region_stats #(
    .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .out_valid(out_valid),
    .out_found(out_found), .out_count(out_count), .out_x_min(out_x_min),
    .out_x_max(out_x_max), .out_y_min(out_y_min), .out_y_max(out_y_max),
    .out_cx(out_cx), .out_cy(out_cy), .overrun(overrun)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 ns after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_de = 1'b0; mask = 1'b0; in_hsync = 1'b0;
      step();
    end
  endtask

  // w x h active frame, mask=1 inside the rectangle [x0..x1] x [y0..y1]
  task automatic drive_frame(input int w, input int h, input int x0,
                             input int x1, input int y0, input int y1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        in_de = 1'b1;
        mask  = (c >= x0 && c <= x1 && r >= y0 && r <= y1);
        step();
      end
      in_de = 1'b0; mask = 1'b0; in_hsync = 1'b1;
      step();
      in_hsync = 1'b0;
      step(); step(); step();
    end
  endtask

  // Raise vsync and count edges (boundary edge = 1) until out_valid
  task automatic wait_result(output int n);
    in_vsync = 1'b1;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (n == 3) in_vsync = 1'b0;
      if (out_valid) break;
    end
    in_vsync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; mask = 1'b0; in_de = 1'b0;
    in_hsync = 1'b0; in_vsync = 1'b0;
    step(); step();
    checks++;
    if ({out_valid, out_found, out_count, out_x_min, out_x_max, out_y_min,
         out_y_max, out_cx, out_cy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got count=%0d found=%0b valid=%0b, want all zero",
               out_count, out_found, out_valid);
    end
    rst = 1'b0; ce = 1'b1;
    idle(3);
  endtask

  task automatic test_single_pixel();
    int n;
    drive_frame(8, 6, 3, 3, 2, 2);
    wait_result(n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL single_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if ({out_found, out_count} !== {1'b1, CNT_W'(1)}) begin
      errors++; $display("FAIL single_count: got found=%0b count=%0d want 1/1", out_found, out_count);
    end
    checks++;
    if ({out_x_min, out_x_max, out_y_min, out_y_max} !== {X_W'(3), X_W'(3), Y_W'(2), Y_W'(2)}) begin
      errors++; $display("FAIL single_bbox: got %0d/%0d/%0d/%0d want 3/3/2/2",
                         out_x_min, out_x_max, out_y_min, out_y_max);
    end
    checks++;
    if ({out_cx, out_cy} !== {X_W'(3), Y_W'(2)}) begin
      errors++; $display("FAIL single_centroid: got %0d,%0d want 3,2", out_cx, out_cy);
    end
    step();
    checks++;
    if ({out_valid, out_count} !== {1'b0, CNT_W'(1)}) begin
      errors++; $display("FAIL single_hold: got valid=%0b count=%0d want 0/1", out_valid, out_count);
    end
    idle(2);
  endtask

  task automatic test_full_frame();
    int n;
    drive_frame(8, 6, 0, 7, 0, 5);
    wait_result(n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL full_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if ({out_found, out_count} !== {1'b1, CNT_W'(48)}) begin
      errors++; $display("FAIL full_count: got found=%0b count=%0d want 1/48", out_found, out_count);
    end
    checks++;
    if ({out_x_min, out_x_max, out_y_min, out_y_max} !== {X_W'(0), X_W'(7), Y_W'(0), Y_W'(5)}) begin
      errors++; $display("FAIL full_bbox: got %0d/%0d/%0d/%0d want 0/7/0/5",
                         out_x_min, out_x_max, out_y_min, out_y_max);
    end
    checks++;
    if ({out_cx, out_cy} !== {X_W'(3), Y_W'(2)}) begin
      errors++; $display("FAIL full_centroid: got %0d,%0d want 3,2", out_cx, out_cy);
    end
    idle(2);
  endtask

  task automatic test_empty_frame();
    int n;
    drive_frame(8, 6, 1, 0, 1, 0);
    wait_result(n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL empty_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if ({out_found, out_count, out_x_min, out_x_max, out_y_min, out_y_max,
         out_cx, out_cy} !== '0) begin
      errors++; $display("FAIL empty_outputs: got found=%0b count=%0d bbox %0d/%0d/%0d/%0d c=%0d,%0d want all 0",
                         out_found, out_count, out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int n;
    drive_frame(8, 6, 5, 6, 4, 5);
    wait_result(n);
    checks++;
    if ({out_found, out_count, out_cx, out_cy} !== {1'b1, CNT_W'(4), X_W'(5), Y_W'(4)}) begin
      errors++; $display("FAIL b2b_first: got count=%0d c=%0d,%0d want 4 c=5,4", out_count, out_cx, out_cy);
    end
    checks++;
    if ({out_x_min, out_x_max, out_y_min, out_y_max} !== {X_W'(5), X_W'(6), Y_W'(4), Y_W'(5)}) begin
      errors++; $display("FAIL b2b_first_bbox: got %0d/%0d/%0d/%0d want 5/6/4/5",
                         out_x_min, out_x_max, out_y_min, out_y_max);
    end
    idle(2);
    drive_frame(8, 6, 0, 0, 0, 0);
    wait_result(n);
    checks++;
    if ({out_found, out_count, out_cx, out_cy} !== {1'b1, CNT_W'(1), X_W'(0), Y_W'(0)}) begin
      errors++; $display("FAIL b2b_second: got count=%0d c=%0d,%0d want 1 c=0,0", out_count, out_cx, out_cy);
    end
    checks++;
    if ({out_x_min, out_x_max, out_y_min, out_y_max} !== '0) begin
      errors++; $display("FAIL b2b_second_bbox: got %0d/%0d/%0d/%0d want 0/0/0/0",
                         out_x_min, out_x_max, out_y_min, out_y_max);
    end
    idle(2);
  endtask

  task automatic test_overrun();
    int n, ovr_cnt, ovr_at, valid_cnt, valid_at;
    logic [CNT_W-1:0] cap_count;
    logic [X_W-1:0]   cap_xmin, cap_xmax, cap_cx;
    logic [Y_W-1:0]   cap_ymin, cap_ymax, cap_cy;
    drive_frame(8, 6, 1, 2, 0, 0);
    in_vsync = 1'b1;
    n = 0; ovr_cnt = 0; ovr_at = -1; valid_cnt = 0; valid_at = -1;
    cap_count = '0; cap_xmin = '0; cap_xmax = '0; cap_cx = '0;
    cap_ymin = '0; cap_ymax = '0; cap_cy = '0;
    while (n < 160) begin
      step();
      n++;
      if (n == 3)  in_vsync = 1'b0;
      if (n == 40) in_vsync = 1'b1;
      if (n == 43) in_vsync = 1'b0;
      if (overrun) begin ovr_cnt++; ovr_at = n; end
      if (out_valid) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = n; cap_count = out_count; cap_cx = out_cx; cap_cy = out_cy;
          cap_xmin = out_x_min; cap_xmax = out_x_max; cap_ymin = out_y_min; cap_ymax = out_y_max;
        end
      end
    end
    checks++;
    if ({ovr_cnt, ovr_at} !== {32'd1, 32'd41}) begin
      errors++; $display("FAIL overrun_pulse: got %0d pulses last at %0d want 1 at 41", ovr_cnt, ovr_at);
    end
    checks++;
    if ({valid_cnt, valid_at} !== {32'd1, 32'd66}) begin
      errors++; $display("FAIL overrun_valid: got %0d pulses first at %0d want 1 at 66", valid_cnt, valid_at);
    end
    checks++;
    if ({cap_count, cap_xmin, cap_xmax, cap_ymin, cap_ymax, cap_cx, cap_cy} !==
        {CNT_W'(2), X_W'(1), X_W'(2), Y_W'(0), Y_W'(0), X_W'(1), Y_W'(0)}) begin
      errors++; $display("FAIL overrun_result: got count=%0d bbox %0d/%0d/%0d/%0d c=%0d,%0d want 2 1/2/0/0 c=1,0",
                         cap_count, cap_xmin, cap_xmax, cap_ymin, cap_ymax, cap_cx, cap_cy);
    end
    idle(2);
  endtask

  task automatic test_ce_toggle();
    int en, k;
    logic was;
    drive_frame(8, 6, 2, 4, 1, 3);
    in_vsync = 1'b1;
    step();
    en = 1; k = 0;
    while (k < 300) begin
      ce = (k % 2 == 0) ? 1'b0 : 1'b1;
      was = ce;
      step();
      k++;
      if (was) en++;
      if (k == 4) in_vsync = 1'b0;
      if (out_valid) break;
    end
    in_vsync = 1'b0;
    checks++;
    if (en !== LAT) begin
      errors++; $display("FAIL ce_latency: got %0d enabled cycles want %0d", en, LAT);
    end
    checks++;
    if ({out_count, out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy} !==
        {CNT_W'(9), X_W'(2), X_W'(4), Y_W'(1), Y_W'(3), X_W'(3), Y_W'(2)}) begin
      errors++; $display("FAIL ce_result: got count=%0d bbox %0d/%0d/%0d/%0d c=%0d,%0d want 9 2/4/1/3 c=3,2",
                         out_count, out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy);
    end
    ce = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL ce_freeze: got valid=%0b want 1 while ce=0", out_valid);
    end
    ce = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ce_release: got valid=%0b want 0", out_valid);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_div();
    int n, seen;
    drive_frame(8, 6, 5, 5, 1, 1);
    in_vsync = 1'b1;
    step();
    for (int i = 1; i < 30; i++) begin
      if (i == 3) in_vsync = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_found, out_count, out_x_min, out_x_max, out_y_min,
         out_y_max, out_cx, out_cy, overrun} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got count=%0d found=%0b cx=%0d want all zero",
                         out_count, out_found, out_cx);
    end
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", seen);
    end
    drive_frame(8, 6, 4, 4, 3, 3);
    wait_result(n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL midrst_next_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if ({out_found, out_count, out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy} !==
        {1'b1, CNT_W'(1), X_W'(4), X_W'(4), Y_W'(3), Y_W'(3), X_W'(4), Y_W'(3)}) begin
      errors++; $display("FAIL midrst_next_result: got count=%0d bbox %0d/%0d/%0d/%0d c=%0d,%0d want 1 4/4/3/3 c=4,3",
                         out_count, out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_empty_frame();
    test_back_to_back();
    test_overrun();
    test_ce_toggle();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
